can_spi_readout: RTL and testbench
==================================

// Module: can_spi_readout
// PURPOSE
//  Downstream of the CAN frame-capture path. Each completed frame's decoded fields are captured
//  into a small record FIFO, and the oldest record is served to an external host over a
//  mode-0 SPI slave. The SPI slave is oversampled on the system clock, with no second clock domain.
//  Drives pmod_3 (MISO) from pmod_2/pmod_4 (SCK/CS_n).
// PARAMETERS
//  DEPTH       2    record FIFO depth (power of 2, >=2)
//  SYNC_STAGES 2    synchroniser flops on frame_done, spi_sck, spi_cs_n
//  REC_WIDTH   104  bits per record: {status[7:0], id[31:0], payload[63:0]}; fixed
// PORTS
//  clk           in   1   12 MHz system clock
//  rst           in   1   asynchronous, active-high reset
//  frame_done    in   1   level from capture state machine; rising edge = frame complete
//  frame_ext     in   1   1 = 29-bit extended ID
//  frame_rtr     in   1   remote frame flag
//  frame_dlc     in   4   data length code (stored raw; 9..15 stored unchanged)
//  frame_id      in   29  identifier, right-aligned (std ID in [10:0])
//  frame_payload in   64  data bytes, byte0 in [63:56]
//  spi_sck       in   1   host SPI clock (async)
//  spi_cs_n      in   1   host chip select, active low (async)
//  spi_miso      out  1   serial data out, MSB first
//  rec_count     out  $clog2(DEPTH)+1  records held
//  rec_avail     out  1   rec_count != 0 (host interrupt)
//  overflow      out  1   sticky: a frame was dropped
// BEHAVIOUR
//  Reset (any time, incl. mid-transfer): FIFO empty, rec_count=0, rec_avail=0, overflow=0,
//   spi_miso=0, shifter cleared, bit counter=0, transfer state IDLE.
//  Capture: frame_done passes through SYNC_STAGES flops, and then a rising-edge detect produces push.
//   frame_* are sampled on the push cycle. The integrator keeps frame_* stable >= SYNC_STAGES+2 clk
//   after frame_done rises.
//   Record = {1'b1, overflow, frame_ext, frame_rtr, frame_dlc, 3'b000, frame_id, frame_payload}.
//   The overflow bit is the value of the sticky flag at push time.
//  Full: push dropped, overflow<=1. Push and pop in the same cycle when full: both take effect,
//   so the new record is stored. Push and pop in the same cycle when empty cannot occur, because
//   pop requires a loaded valid record.
//  overflow clears on pop of a record whose status overflow bit = 1. A drop in the same cycle
//   wins: overflow stays 1.
//  Pointers wrap modulo DEPTH. rec_count updates the cycle after push/pop (registered).
//  SPI (mode 0, MSB first): sck and cs_n are synchronised, then edge-detected on clk.
//   Supported SCK <= clk/8.
//   States: IDLE -> LOAD -> SHIFT -> DONE.
//   IDLE: on cs_n fall -> LOAD.
//   LOAD (1 clk): shifter <= head record if not empty, else 104'b0 (status.valid=0).
//    spi_miso <= shifter MSB; bit counter=0; go to SHIFT.
//   SHIFT: on each sync'd sck fall, shift left and increment the counter.
//    After 104 sck rises the counter saturates at 104 and spi_miso=0.
//   cs_n rise (any state) -> DONE (1 clk): pop if counter==104 and the loaded record was valid.
//    Partial read: no pop, so the same record is re-served next time. Then go to IDLE.
//   spi_miso=0 whenever cs_n is high.
//   Sync'd sck edges while cs_n is high are ignored.
//  Latency: frame_done rise to rec_avail=1 is SYNC_STAGES+2 clk.
//   cs_n fall to first valid MISO bit is SYNC_STAGES+2 clk.
// STRUCTURE
//  Shared package can_pkg: REC_WIDTH, status bit offsets (VALID=7, OVF=6, EXT=5, RTR=4,
//   DLC=3:0), ID_MSB/PAYLOAD_MSB field offsets, SPI state encoding.
//  Sub-module sync_edge #(STAGES): synchroniser + rise/fall pulses.
//   Instantiated 3x (frame_done, spi_sck, spi_cs_n).
//  FIFO storage is an array of REC_WIDTH registers, kept inline.
// TESTING
//  1. Std frame id=0x123, dlc=8, payload=0x0102030405060708, read 104 bits.
//     -> 0x88_00000123_0102030405060708; rec_count 1->0.
//  2. Read while empty -> 104 zero bits; rec_count stays 0; no pointer movement.
//  3. Ext id=0x1ABCDEF0, rtr=1, dlc=0; CS released after 40 bits; re-read.
//     -> both reads start 0xB0_1ABCDEF0; pop only after the full read.
//  4. Three frames with DEPTH=2, no reads.
//     -> overflow=1, rec_count=2; the record from the 3rd frame is never stored.
//     Reading both records clears overflow only after the 2nd record (OVF bit=0 then 1 in status).
//  5. FIFO full and frame_done rising in the same clk that the DONE pop fires
//     -> record stored, rec_count stays 2, overflow stays 0.
//  6. Assert rst at bit 50 of a transfer -> spi_miso=0, rec_count=0 next clk.
//     A new frame after release reads back correctly.

Source files
------------

// File: rtl/can_spi_readout_pkg.sv
// Shared record layout and SPI state encoding for the CAN readout path.
// Field offsets are absolute bit positions within one record.
package can_pkg;

    localparam int REC_WIDTH   = 104;
    localparam int STATUS_LSB  = 96;
    localparam int ST_VALID    = 7;
    localparam int ST_OVF      = 6;
    localparam int ST_EXT      = 5;
    localparam int ST_RTR      = 4;
    localparam int ST_DLC_MSB  = 3;
    localparam int ID_MSB      = 95;
    localparam int PAYLOAD_MSB = 63;
    localparam int CNT_W       = $clog2(REC_WIDTH + 1);

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_LOAD,
        SPI_SHIFT,
        SPI_DONE
    } spi_state_t;

    function automatic logic [REC_WIDTH-1:0] make_record(
        input logic        ovf,
        input logic        ext,
        input logic        rtr,
        input logic [3:0]  dlc,
        input logic [28:0] id,
        input logic [63:0] payload
    );
        return {1'b1, ovf, ext, rtr, dlc, 3'b000, id, payload};
    endfunction

endpackage

// File: rtl/can_spi_readout_if.sv
// Frame-capture inputs, host SPI pins and status outputs of the readout block.
// The capture side and host drive through master; the readout block is slave.
interface can_spi_readout_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          frame_done;
    logic          frame_ext;
    logic          frame_rtr;
    logic [3:0]    frame_dlc;
    logic [28:0]   frame_id;
    logic [63:0]   frame_payload;
    logic          spi_sck;
    logic          spi_cs_n;
    logic          spi_miso;
    logic [CW-1:0] rec_count;
    logic          rec_avail;
    logic          overflow;

    modport master (
        output frame_done, frame_ext, frame_rtr, frame_dlc,
        output frame_id, frame_payload, spi_sck, spi_cs_n,
        input  spi_miso, rec_count, rec_avail, overflow
    );

    modport slave (
        input  frame_done, frame_ext, frame_rtr, frame_dlc,
        input  frame_id, frame_payload, spi_sck, spi_cs_n,
        output spi_miso, rec_count, rec_avail, overflow
    );

endinterface

// File: rtl/can_spi_readout_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with rise/fall pulses.
// INIT sets the idle level so reset does not fake an edge (e.g. cs_n idles high).
module sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sr;
    logic              prev;

    // Shift the async input through the chain and remember the last level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= {STAGES{INIT}};
            prev <= INIT;
        end else begin
            sr   <= {sr[STAGES-2:0], d};
            prev <= sr[STAGES-1];
        end
    end

    assign level = sr[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/can_spi_readout.sv
// Captures completed CAN frames into a record FIFO and serves the oldest
// record to a host over an oversampled mode-0 SPI slave.
module can_spi_readout
    import can_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    can_spi_readout_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REC_WIDTH);

    logic fd_rise, sck_fall, cs_fall, cs_rise, cs_lvl;
    logic unused_fd_lvl, unused_fd_fall;
    logic unused_sck_lvl, unused_sck_rise;

    logic [REC_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]        fill, rec_count_q;
    logic [AW-1:0]        tail_idx;
    logic                 overflow_q, full, empty;
    logic                 push, pop, do_wr, drop;
    logic [REC_WIDTH-1:0] head_rec, shifter;
    spi_state_t           state_q, state_d;
    logic                 load_en, shift_en;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 miso_q, ld_valid, ld_ovf;

    sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_fd (
        .clk(clk), .rst(rst), .d(bus.frame_done),
        .level(unused_fd_lvl), .rise(fd_rise), .fall(unused_fd_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck (
        .clk(clk), .rst(rst), .d(bus.spi_sck),
        .level(unused_sck_lvl), .rise(unused_sck_rise), .fall(sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
        .clk(clk), .rst(rst), .d(bus.spi_cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    assign push     = fd_rise;
    assign fill     = wr_ptr - rd_ptr;
    assign full     = (fill == CW'(DEPTH));
    assign empty    = (fill == '0);
    assign do_wr    = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign tail_idx = wr_ptr[AW-1:0] - AW'(1);
    assign head_rec = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Record storage; a drop tags the newest held record so the host
    // can tell that frames went missing right after it.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= make_record(
                overflow_q, bus.frame_ext, bus.frame_rtr,
                bus.frame_dlc, bus.frame_id, bus.frame_payload);
        end else if (drop) begin
            mem[tail_idx][STATUS_LSB+ST_OVF] <= 1'b1;
        end
    end

    // Pointers, registered count and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rec_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            rec_count_q <= fill;
            if (drop) overflow_q <= 1'b1;
            else if (pop && ld_ovf) overflow_q <= 1'b0;
        end
    end

    // Transfer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SPI_IDLE;
        else     state_q <= state_d;
    end

    // Next transfer state and per-cycle strobes.
    always_comb begin
        state_d  = state_q;
        load_en  = 1'b0;
        shift_en = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            SPI_IDLE:  if (cs_fall) state_d = SPI_LOAD;
            SPI_LOAD: begin
                load_en = 1'b1;
                state_d = SPI_SHIFT;
            end
            SPI_SHIFT: shift_en = sck_fall & ~cs_lvl;
            SPI_DONE: begin
                pop     = ld_valid & (bit_cnt == LAST);
                state_d = cs_fall ? SPI_LOAD : SPI_IDLE;
            end
            default:   state_d = SPI_IDLE;
        endcase
        if (cs_rise && state_q != SPI_DONE) state_d = SPI_DONE;
    end

    // Shifter, bit counter and MISO register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shifter  <= '0;
            bit_cnt  <= '0;
            miso_q   <= 1'b0;
            ld_valid <= 1'b0;
            ld_ovf   <= 1'b0;
        end else if (load_en) begin
            shifter  <= head_rec;
            miso_q   <= head_rec[REC_WIDTH-1];
            bit_cnt  <= '0;
            ld_valid <= head_rec[STATUS_LSB+ST_VALID];
            ld_ovf   <= head_rec[STATUS_LSB+ST_OVF];
        end else if (shift_en && bit_cnt != LAST) begin
            shifter <= {shifter[REC_WIDTH-2:0], 1'b0};
            miso_q  <= shifter[REC_WIDTH-2];
            bit_cnt <= bit_cnt + CNT_W'(1);
        end else if (state_q == SPI_DONE) begin
            miso_q <= 1'b0;
        end
    end

    assign bus.spi_miso  = miso_q & ~cs_lvl;
    assign bus.rec_count = rec_count_q;
    assign bus.rec_avail = (rec_count_q != '0);
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_can_spi_readout.sv
// Self-checking bench for can_spi_readout: table of frames, scoreboard
// of expected records, plus partial-read, overflow, same-cycle and reset sequences.
module tb_can_spi_readout;

    localparam int DEPTH = 2;

    typedef struct {
        logic        ext;
        logic        rtr;
        logic [3:0]  dlc;
        logic [28:0] id;
        logic [63:0] pl;
        logic [7:0]  st;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    can_spi_readout_if #(.DEPTH(DEPTH)) bus ();

    can_spi_readout #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    vec_t           vec [6];
    logic [103:0]   sb_q [$];
    logic           m_ovf = 1'b0;
    int             checks = 0;
    int             errors = 0;

    task automatic check(input string nm, input logic [103:0] act,
                         input logic [103:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_push(input int k);
        logic [103:0] r;
        r = {vec[k].st, 3'b000, vec[k].id, vec[k].pl};
        if (sb_q.size() < DEPTH) begin
            if (m_ovf) r[102] = 1'b1;
            sb_q.push_back(r);
        end else begin
            m_ovf = 1'b1;
            r = sb_q[sb_q.size()-1];
            r[102] = 1'b1;
            sb_q[sb_q.size()-1] = r;
        end
    endtask

    task automatic model_pop(output logic [103:0] e);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e[102]) m_ovf = 1'b0;
        end else begin
            e = '0;
        end
    endtask

    task automatic drive_frame(input int k);
        bus.frame_ext     = vec[k].ext;
        bus.frame_rtr     = vec[k].rtr;
        bus.frame_dlc     = vec[k].dlc;
        bus.frame_id      = vec[k].id;
        bus.frame_payload = vec[k].pl;
        bus.frame_done    = 1'b1;
        repeat (6) @(negedge clk);
        bus.frame_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input string nm, input int k);
        @(negedge clk);
        drive_frame(k);
        model_push(k);
        check({nm, ".count"}, 104'(bus.rec_count), 104'(sb_q.size()));
        check({nm, ".avail"}, 104'(bus.rec_avail), 104'(sb_q.size() != 0));
        check({nm, ".ovf"}, 104'(bus.overflow), 104'(m_ovf));
    endtask

    task automatic cs_low();
        @(negedge clk);
        bus.spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        bus.spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic shift_bits(input int n, output logic [103:0] d);
        d = '0;
        for (int i = 0; i < n; i++) begin
            d = {d[102:0], bus.spi_miso};
            bus.spi_sck = 1'b1;
            repeat (5) @(negedge clk);
            bus.spi_sck = 1'b0;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic full_read(input string nm);
        logic [103:0] d, e;
        logic         tail;
        cs_low();
        shift_bits(104, d);
        tail = bus.spi_miso;
        cs_high();
        model_pop(e);
        check({nm, ".data"}, d, e);
        check({nm, ".tail"}, 104'(tail), 104'(0));
        check({nm, ".count"}, 104'(bus.rec_count), 104'(sb_q.size()));
        check({nm, ".ovf"}, 104'(bus.overflow), 104'(m_ovf));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [103:0] d, e;

        vec[0] = '{1'b0, 1'b0, 4'd8,  29'h123,      64'h0102030405060708, 8'h88};
        vec[1] = '{1'b1, 1'b1, 4'd0,  29'h1ABCDEF0, 64'h0,                8'hB0};
        vec[2] = '{1'b0, 1'b0, 4'd15, 29'h7FF,      64'hFEDCBA9876543210, 8'h8F};
        vec[3] = '{1'b1, 1'b0, 4'd4,  29'h1FFFFFFF, 64'hDEADBEEF00000000, 8'hA4};
        vec[4] = '{1'b0, 1'b1, 4'd9,  29'h0,        64'hA5A5A5A55A5A5A5A, 8'h99};
        vec[5] = '{1'b0, 1'b0, 4'd8,  29'h555,      64'hFFFFFFFFFFFFFFFF, 8'h88};

        bus.frame_done    = 1'b0;
        bus.frame_ext     = 1'b0;
        bus.frame_rtr     = 1'b0;
        bus.frame_dlc     = '0;
        bus.frame_id      = '0;
        bus.frame_payload = '0;
        bus.spi_sck       = 1'b0;
        bus.spi_cs_n      = 1'b1;

        repeat (3) @(negedge clk);
        check("rst.count", 104'(bus.rec_count), 104'(0));
        check("rst.avail", 104'(bus.rec_avail), 104'(0));
        check("rst.ovf",   104'(bus.overflow),  104'(0));
        check("rst.miso",  104'(bus.spi_miso),  104'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        full_read("empty");

        for (int k = 0; k < 5; k++) begin
            send($sformatf("vec%0d.push", k), k);
            full_read($sformatf("vec%0d.read", k));
        end

        send("part.push", 1);
        cs_low();
        shift_bits(40, d);
        cs_high();
        e = sb_q[0];
        check("part.bits", 104'(d[39:0]), 104'(e[103:64]));
        check("part.count", 104'(bus.rec_count), 104'(1));
        full_read("part.reread");

        send("ovf.a", 0);
        send("ovf.b", 1);
        send("ovf.c", 2);
        check("ovf.count2", 104'(bus.rec_count), 104'(2));
        check("ovf.flag", 104'(bus.overflow), 104'(1));
        full_read("ovf.read1");
        full_read("ovf.read2");

        send("same.d", 3);
        send("same.e", 4);
        cs_low();
        shift_bits(104, d);
        bus.spi_cs_n = 1'b1;
        @(negedge clk);
        drive_frame(0);
        repeat (4) @(negedge clk);
        model_pop(e);
        model_push(0);
        check("same.data", d, e);
        check("same.count", 104'(bus.rec_count), 104'(2));
        check("same.ovf", 104'(bus.overflow), 104'(0));
        full_read("same.read_e");
        full_read("same.read_f");

        send("rst.g", 5);
        cs_low();
        shift_bits(50, d);
        check("rst.pre_miso", 104'(bus.spi_miso), 104'(1));
        rst = 1'b1;
        #1;
        check("rst.mid_miso", 104'(bus.spi_miso), 104'(0));
        @(posedge clk);
        #1;
        check("rst.mid_count", 104'(bus.rec_count), 104'(0));
        check("rst.mid_avail", 104'(bus.rec_avail), 104'(0));
        bus.spi_cs_n = 1'b1;
        bus.spi_sck  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        m_ovf = 1'b0;
        repeat (4) @(negedge clk);
        send("rst.h", 2);
        full_read("rst.read_h");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
